qdr_rr_arbiter: RTL and testbench
=================================

// Module: qdr_rr_arbiter
// PURPOSE
//   Shares one QDR controller master port among NUM_PORTS fabric requesters using round-robin.
//   Sits between the fabric slave ports and the QDR sniffer/controller slave interface.
//   Read data is routed back to the issuing requester through an in-order tag FIFO.
//   Master-side commands are registered: one cycle from accept to the master bus.
// PARAMETERS
//   NUM_PORTS      4   number of requesters (2..8)
//   QDR_ADDR_WIDTH 32  address width per port
//   QDR_DATA_WIDTH 18  half-word data width; buses are 2*QDR_DATA_WIDTH
//   QDR_BW_WIDTH   2   half-word byte-enable width; buses are 2*QDR_BW_WIDTH
//   TAG_DEPTH      16  maximum outstanding reads (power of 2)
// PORTS
//   qdr_clk        in   1                           single clock
//   qdr_rst_n      in   1                           asynchronous reset, active-low
//   req_addr       in   NUM_PORTS*QDR_ADDR_WIDTH    per-port address, port i at slice i
//   req_wr_strb    in   NUM_PORTS                   per-port write request
//   req_wr_data    in   NUM_PORTS*2*QDR_DATA_WIDTH  per-port write data
//   req_wr_be      in   NUM_PORTS*2*QDR_BW_WIDTH    per-port byte enables
//   req_rd_strb    in   NUM_PORTS                   per-port read request
//   req_ack        out  NUM_PORTS                   one-hot; request accepted this cycle
//   req_rd_data    out  2*QDR_DATA_WIDTH            read data, broadcast to all ports
//   req_rd_dvld    out  NUM_PORTS                   one-hot; req_rd_data valid for port i
//   master_addr    out  QDR_ADDR_WIDTH              to QDR controller
//   master_wr_strb out  1                           to QDR controller
//   master_wr_data out  2*QDR_DATA_WIDTH            to QDR controller
//   master_wr_be   out  2*QDR_BW_WIDTH              to QDR controller
//   master_rd_strb out  1                           to QDR controller
//   master_ack     in   1                           controller accepts a command this cycle
//   master_rd_data in   2*QDR_DATA_WIDTH            read return data
//   master_rd_dvld in   1                           read return valid; in command order
//   tag_err        out  1                           sticky; dvld received with tag FIFO empty
// BEHAVIOUR
//   Reset (qdr_rst_n=0, async) drives these outputs low immediately:
//     req_ack, req_rd_dvld, master_*, tag_err.
//   Reset also clears the RR pointer to 0 and empties the tag FIFO; outstanding reads are discarded.
//   Port i is a request when req_wr_strb[i] | req_rd_strb[i].
//   A requesting port is eligible unless req_rd_strb[i]=1 and the tag FIFO holds TAG_DEPTH entries.
//   Grant is combinational in cycle t and gated by slot_free:
//     slot_free = !master_wr_strb & !master_rd_strb | master_ack.
//     The granted port is the first eligible port scanning up from ptr, modulo NUM_PORTS.
//     req_ack[grant] is high in cycle t only.
//   On the accepting edge:
//     - The granted port's addr, data, be and strobes are registered onto master_*.
//     - ptr <= grant+1, wrapping NUM_PORTS-1 -> 0.
//     - If rd_strb is set, the grant index is pushed into the tag FIFO.
//   A port with both strobes set issues one combined command: a QDR write and a read in the same slot.
//   master_* hold their values while master_ack=0.
//   Strobes clear after master_ack unless a new grant loads them on the same edge (back-to-back).
//   Requesters hold their strobes and fields stable until req_ack; dropping a strobe earlier is legal.
//   Read return: on master_rd_dvld the FIFO head is popped.
//     Next cycle: req_rd_dvld[head]=1 and req_rd_data=master_rd_data. Latency is 1 cycle.
//   Push and pop on the same edge are both honoured; the count is unchanged.
//   Full-FIFO read eligibility is decided on registered count only, with no bypass from pop.
//   dvld with an empty FIFO: no req_rd_dvld, tag_err <= 1. tag_err clears only on reset.
//   A lone requester is granted on every free slot, giving full throughput.
//   With no requests, ptr holds.
// TESTING
//   1. Reset mid-burst.
//      Stimulus: 3 reads outstanding, then pulse qdr_rst_n low.
//      Required: all outputs 0; later dvld pulses raise tag_err; the next read returns to the correct port.
//   2. Round-robin fairness.
//      Stimulus: all 4 ports request writes continuously, master_ack=1.
//      Required: grants follow 0,1,2,3,0,1...; each command appears on master_* one cycle after its ack.
//   3. Read routing.
//      Stimulus: ports 2, 0 and 3 each read once; controller returns 0xA, 0xB, 0xC after latency 10.
//      Required: req_rd_dvld = 0100, 0001, 1000 with data A, B, C.
//   4. Tag FIFO full.
//      Stimulus: TAG_DEPTH=4, port 1 issues 5 reads with no dvld returned.
//      Required: 4 acks, the 5th stalls; it is acked the cycle after the first dvld.
//      Concurrently: a write from port 0 during the stall is still acked.
//   5. Master backpressure.
//      Stimulus: hold master_ack=0 for 5 cycles with port 3 writing addr 0x100.
//      Required: master_* stable at addr 0x100 and no further req_ack until master_ack rises.
//   6. Combined request.
//      Stimulus: port 0 sets wr+rd with addr 0x20.
//      Required: master_wr_strb=master_rd_strb=1 in the same cycle; one tag pushed; one dvld to port 0.

Source files
------------

// File: rtl/qdr_rr_arbiter.sv
// Round-robin arbiter sharing one QDR controller master port among NUM_PORTS requesters.
// Read returns are steered back to the issuing port through an in-order tag FIFO.
module qdr_rr_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int QDR_ADDR_WIDTH = 32,
  parameter int QDR_DATA_WIDTH = 18,
  parameter int QDR_BW_WIDTH   = 2,
  parameter int TAG_DEPTH      = 16
) (
  input  logic                                  qdr_clk,
  input  logic                                  qdr_rst_n,
  input  logic [NUM_PORTS*QDR_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS-1:0]                  req_wr_strb,
  input  logic [NUM_PORTS*2*QDR_DATA_WIDTH-1:0] req_wr_data,
  input  logic [NUM_PORTS*2*QDR_BW_WIDTH-1:0]   req_wr_be,
  input  logic [NUM_PORTS-1:0]                  req_rd_strb,
  output logic [NUM_PORTS-1:0]                  req_ack,
  output logic [2*QDR_DATA_WIDTH-1:0]           req_rd_data,
  output logic [NUM_PORTS-1:0]                  req_rd_dvld,
  output logic [QDR_ADDR_WIDTH-1:0]             master_addr,
  output logic                                  master_wr_strb,
  output logic [2*QDR_DATA_WIDTH-1:0]           master_wr_data,
  output logic [2*QDR_BW_WIDTH-1:0]             master_wr_be,
  output logic                                  master_rd_strb,
  input  logic                                  master_ack,
  input  logic [2*QDR_DATA_WIDTH-1:0]           master_rd_data,
  input  logic                                  master_rd_dvld,
  output logic                                  tag_err
);

  localparam int PW  = $clog2(NUM_PORTS);
  localparam int TW  = $clog2(TAG_DEPTH);
  localparam int DBW = 2*QDR_DATA_WIDTH;
  localparam int BEW = 2*QDR_BW_WIDTH;
  localparam logic [NUM_PORTS-1:0] PORT0     = NUM_PORTS'(1);
  localparam logic [PW-1:0]        LAST_PORT = PW'(NUM_PORTS-1);
  localparam logic [TW:0]          FULL_CNT  = TAG_DEPTH[TW:0];

  logic [PW-1:0]        ptr;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        scan_idx;
  logic                 grant_vld;
  logic                 slot_free;
  logic                 accept;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic [NUM_PORTS-1:0] request;
  logic [NUM_PORTS-1:0] eligible;
  logic [PW-1:0]        tag_mem [TAG_DEPTH];
  logic [TW-1:0]        wr_ptr;
  logic [TW-1:0]        rd_ptr;
  logic [TW:0]          count;

  assign request   = req_wr_strb | req_rd_strb;
  // Full is judged on the registered count only; a same-cycle pop does not free a slot.
  assign fifo_full = (count == FULL_CNT);
  assign eligible  = request & ~(req_rd_strb & {NUM_PORTS{fifo_full}});
  assign slot_free = (!master_wr_strb && !master_rd_strb) || master_ack;

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      scan_idx = PW'((int'(ptr) + i) % NUM_PORTS);
      if (eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Reset gates the combinational ack so it falls immediately with qdr_rst_n.
  assign accept  = slot_free && grant_vld && qdr_rst_n;
  assign req_ack = accept ? (PORT0 << grant_idx) : '0;
  assign push    = accept && req_rd_strb[grant_idx];
  assign pop     = master_rd_dvld && (count != '0);

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      ptr            <= '0;
      master_addr    <= '0;
      master_wr_strb <= 1'b0;
      master_wr_data <= '0;
      master_wr_be   <= '0;
      master_rd_strb <= 1'b0;
    end else if (accept) begin
      ptr            <= (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
      master_addr    <= req_addr[grant_idx*QDR_ADDR_WIDTH +: QDR_ADDR_WIDTH];
      master_wr_strb <= req_wr_strb[grant_idx];
      master_wr_data <= req_wr_data[grant_idx*DBW +: DBW];
      master_wr_be   <= req_wr_be[grant_idx*BEW +: BEW];
      master_rd_strb <= req_rd_strb[grant_idx];
    end else if (master_ack) begin
      master_wr_strb <= 1'b0;
      master_rd_strb <= 1'b0;
    end
  end

  always_ff @(posedge qdr_clk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      req_rd_dvld <= '0;
      req_rd_data <= '0;
      tag_err     <= 1'b0;
    end else begin
      req_rd_dvld <= pop ? (PORT0 << tag_mem[rd_ptr]) : '0;
      if (pop) req_rd_data <= master_rd_data;
      if (master_rd_dvld && (count == '0)) tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qdr_rr_arbiter.sv
// Randomized bench for qdr_rr_arbiter against a queue-based reference model.
// Phases cover fairness, mixed traffic, full tag FIFO, backpressure and mid-burst reset.
module tb_qdr_rr_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 18;
  localparam int BW = 2;
  localparam int TD = 4;

  logic                  qdr_clk = 1'b0;
  logic                  qdr_rst_n = 1'b0;
  logic [NP*AW-1:0]      req_addr = '0;
  logic [NP-1:0]         req_wr_strb = '0;
  logic [NP*2*DW-1:0]    req_wr_data = '0;
  logic [NP*2*BW-1:0]    req_wr_be = '0;
  logic [NP-1:0]         req_rd_strb = '0;
  logic [NP-1:0]         req_ack;
  logic [2*DW-1:0]       req_rd_data;
  logic [NP-1:0]         req_rd_dvld;
  logic [AW-1:0]         master_addr;
  logic                  master_wr_strb;
  logic [2*DW-1:0]       master_wr_data;
  logic [2*BW-1:0]       master_wr_be;
  logic                  master_rd_strb;
  logic                  master_ack = 1'b0;
  logic [2*DW-1:0]       master_rd_data = '0;
  logic                  master_rd_dvld = 1'b0;
  logic                  tag_err;

  qdr_rr_arbiter #(
    .NUM_PORTS(NP), .QDR_ADDR_WIDTH(AW), .QDR_DATA_WIDTH(DW),
    .QDR_BW_WIDTH(BW), .TAG_DEPTH(TD)
  ) dut (
    .qdr_clk(qdr_clk), .qdr_rst_n(qdr_rst_n),
    .req_addr(req_addr), .req_wr_strb(req_wr_strb), .req_wr_data(req_wr_data),
    .req_wr_be(req_wr_be), .req_rd_strb(req_rd_strb), .req_ack(req_ack),
    .req_rd_data(req_rd_data), .req_rd_dvld(req_rd_dvld),
    .master_addr(master_addr), .master_wr_strb(master_wr_strb),
    .master_wr_data(master_wr_data), .master_wr_be(master_wr_be),
    .master_rd_strb(master_rd_strb), .master_ack(master_ack),
    .master_rd_data(master_rd_data), .master_rd_dvld(master_rd_dvld),
    .tag_err(tag_err)
  );

  always #5 qdr_clk = ~qdr_clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Requester side: each port holds its command until acked.
  bit              p_pend [NP];
  bit              p_wr   [NP];
  bit              p_rd   [NP];
  logic [AW-1:0]   p_addr [NP];
  logic [2*DW-1:0] p_data [NP];
  logic [2*BW-1:0] p_be   [NP];

  // Reference model of what the arbiter should present.
  int              m_ptr = 0;
  int              m_tags [$];
  bit              m_mwr = 0, m_mrd = 0;
  logic [AW-1:0]   m_maddr = '0;
  logic [2*DW-1:0] m_mdata = '0;
  logic [2*BW-1:0] m_mbe = '0;
  logic [NP-1:0]   m_dvld = '0;
  logic [2*DW-1:0] m_rdata = '0;
  bit              m_err = 0;

  // Controller side: in-order read return times.
  int ret_t [$];
  int cyc = 0;
  int quiet_until = 0;

  int pct_req, pct_rd, pct_ack, lat_lo, lat_hi;
  bit wr_only;

  task automatic drive_bus();
    for (int i = 0; i < NP; i++) begin
      req_wr_strb[i]              = p_pend[i] && p_wr[i];
      req_rd_strb[i]              = p_pend[i] && p_rd[i];
      req_addr[i*AW +: AW]        = p_addr[i];
      req_wr_data[i*2*DW +: 2*DW] = p_data[i];
      req_wr_be[i*2*BW +: 2*BW]   = p_be[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_tags.delete();
    m_mwr = 0; m_mrd = 0; m_dvld = '0; m_err = 0;
    for (int i = 0; i < NP; i++) p_pend[i] = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, req_ack, '0);
    chk({tag, "_dvld"}, req_rd_dvld, '0);
    chk({tag, "_mwr"}, master_wr_strb, 0);
    chk({tag, "_mrd"}, master_rd_strb, 0);
    chk({tag, "_maddr"}, master_addr, '0);
    chk({tag, "_mdata"}, master_wr_data, '0);
    chk({tag, "_mbe"}, master_wr_be, '0);
    chk({tag, "_err"}, tag_err, 0);
  endtask

  // Reset with all ports requesting so the ack gating is exercised too.
  task automatic do_reset();
    @(negedge qdr_clk);
    req_wr_strb = '1;
    master_ack = 1'b0;
    master_rd_dvld = 1'b0;
    qdr_rst_n = 1'b0;
    #1;
    check_all_zero("rst");
    model_reset();
    drive_bus();
    @(negedge qdr_clk);
    qdr_rst_n = 1'b1;
    quiet_until = cyc + 20;
  endtask

  task automatic step();
    logic [NP-1:0]   exp_ack;
    logic [2*DW-1:0] dv_data;
    bit sfree, dv;
    int g, t;
    @(posedge qdr_clk);
    #1;
    cyc++;
    chk("mwr", master_wr_strb, m_mwr);
    chk("mrd", master_rd_strb, m_mrd);
    if (m_mwr || m_mrd) begin
      chk("maddr", master_addr, m_maddr);
      chk("mdata", master_wr_data, m_mdata);
      chk("mbe", master_wr_be, m_mbe);
    end
    chk("rd_dvld", req_rd_dvld, m_dvld);
    if (m_dvld != '0) chk("rd_data", req_rd_data, m_rdata);
    chk("tag_err", tag_err, m_err);

    for (int i = 0; i < NP; i++) begin
      if (!p_pend[i] && cyc >= quiet_until && $urandom_range(99) < pct_req) begin
        p_pend[i] = 1;
        if (wr_only) begin
          p_wr[i] = 1; p_rd[i] = 0;
        end else begin
          p_rd[i] = ($urandom_range(99) < pct_rd);
          p_wr[i] = !p_rd[i] || ($urandom_range(4) == 0);
        end
        p_addr[i] = $urandom;
        p_data[i] = {$urandom, $urandom};
        p_be[i]   = 4'($urandom);
      end
    end
    drive_bus();
    master_ack = ($urandom_range(99) < pct_ack);
    dv = (ret_t.size() > 0) && (ret_t[0] <= cyc);
    dv_data = {$urandom, $urandom};
    master_rd_dvld = dv;
    master_rd_data = dv_data;
    #1;

    sfree = (!m_mwr && !m_mrd) || master_ack;
    g = -1;
    if (sfree) begin
      for (int k = 0; k < NP; k++) begin
        int j = (m_ptr + k) % NP;
        if (g < 0 && p_pend[j] && !(p_rd[j] && m_tags.size() == TD)) g = j;
      end
    end
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    chk("req_ack", req_ack, exp_ack);

    m_dvld = '0;
    if (dv) begin
      void'(ret_t.pop_front());
      if (m_tags.size() > 0) begin
        m_dvld[m_tags.pop_front()] = 1'b1;
        m_rdata = dv_data;
      end else begin
        m_err = 1;
      end
    end
    if (master_ack && m_mrd) begin
      t = cyc + $urandom_range(lat_hi, lat_lo);
      if (ret_t.size() > 0 && t <= ret_t[$]) t = ret_t[$] + 1;
      ret_t.push_back(t);
    end
    if (g >= 0) begin
      m_mwr = p_wr[g]; m_mrd = p_rd[g];
      m_maddr = p_addr[g]; m_mdata = p_data[g]; m_mbe = p_be[g];
      m_ptr = (g + 1) % NP;
      if (p_rd[g]) m_tags.push_back(g);
      p_pend[g] = 0;
    end else if (master_ack) begin
      m_mwr = 0; m_mrd = 0;
    end
  endtask

  task automatic run_phase(input int n, input int rq, input int rd, input int ak,
                           input int lo, input int hi, input bit wo);
    pct_req = rq; pct_rd = rd; pct_ack = ak; lat_lo = lo; lat_hi = hi; wr_only = wo;
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      p_pend[i] = 0; p_wr[i] = 0; p_rd[i] = 0;
      p_addr[i] = '0; p_data[i] = '0; p_be[i] = '0;
    end
    drive_bus();
    #2;
    check_all_zero("init");
    repeat (2) @(negedge qdr_clk);
    qdr_rst_n = 1'b1;

    run_phase(40, 100, 0, 100, 1, 4, 1);
    run_phase(800, 40, 50, 70, 1, 12, 0);
    do_reset();
    run_phase(800, 60, 80, 90, 15, 30, 0);
    do_reset();
    run_phase(600, 50, 40, 15, 1, 6, 0);
    run_phase(400, 70, 50, 60, 1, 10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
